// File: rtl/rr_bus_arbiter_if.sv
// Bus-side signal bundle for rr_bus_arbiter: requests and lock in, grant status out.
// The arbiter connects through the slave modport and the requesting masters through the master modport.
interface rr_bus_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               lock;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               switch_pulse;
    logic [7:0]         hold_cnt;

    modport master (
        output req, lock,
        input  grant, grant_valid, grant_idx, switch_pulse, hold_cnt
    );

    modport slave (
        input  req, lock,
        output grant, grant_valid, grant_idx, switch_pulse, hold_cnt
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// N-requester bus arbiter with a registered one-hot grant.
// The owner keeps the bus while it requests. Selection is either round-robin,
// starting at the index after the last owner, or fixed priority, where the
// lowest index wins. An optional hold limit forces rotation to waiting
// masters, and the lock input suppresses that forced rotation.
module rr_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_HOLD  = 16,
    parameter int PRIO_MODE = 0
) (
    input  logic           clk,
    input  logic           reset,
    rr_bus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Expiry fires when the owner has already held the bus for MAX_HOLD-1 counted cycles.
    localparam int HOLD_LIMIT = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic               grant_valid_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic               switch_pulse_reg;
    logic [7:0]         hold_cnt_reg;

    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] cand_req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               owner_req;
    logic               expired;
    logic [7:0]         hold_next;
    int                 cand;

    // Decode the current owner and the chosen candidate into one-hot vectors.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign owner_onehot[gi] = (grant_idx_reg == IDX_W'(gi));
            assign pick_onehot[gi]  = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    // While owned, the owner is never a candidate for a hand-over. From IDLE,
    // the last owner is the final candidate of the round-robin scan.
    assign cand_req  = (state_reg == OWNED) ? (bus.req & ~owner_onehot) : bus.req;
    assign owner_req = |(bus.req & owner_onehot);
    assign expired   = (MAX_HOLD != 0) && (int'(hold_cnt_reg) >= HOLD_LIMIT);
    assign hold_next = (hold_cnt_reg == 8'hFF) ? 8'hFF : (hold_cnt_reg + 8'd1);

    // Pick the next owner. The loops run from the farthest candidate to the
    // nearest one, so the last match written is the winner.
    always_comb begin
        pick_idx   = grant_idx_reg;
        pick_found = |cand_req;
        cand       = 0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (cand_req[i]) begin
                    pick_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = int'(grant_idx_reg) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (cand_req[cand]) begin
                    pick_idx = IDX_W'(cand);
                end
            end
        end
    end

    // Ownership state machine. All outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            grant_reg        <= '0;
            grant_valid_reg  <= 1'b0;
            grant_idx_reg    <= IDX_W'(NUM_REQ - 1);
            switch_pulse_reg <= 1'b0;
            hold_cnt_reg     <= 8'd0;
        end else begin
            switch_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg        <= OWNED;
                        grant_reg        <= pick_onehot;
                        grant_valid_reg  <= 1'b1;
                        grant_idx_reg    <= pick_idx;
                        hold_cnt_reg     <= 8'd0;
                        switch_pulse_reg <= 1'b1;
                    end
                end
                OWNED: begin
                    if ((!owner_req || (expired && !bus.lock)) && pick_found) begin
                        // Hand the bus over, either on release or on forced rotation.
                        grant_reg        <= pick_onehot;
                        grant_idx_reg    <= pick_idx;
                        hold_cnt_reg     <= 8'd0;
                        switch_pulse_reg <= 1'b1;
                    end else if (!owner_req) begin
                        // Release with nobody waiting: go idle. grant_idx keeps the last owner.
                        state_reg       <= IDLE;
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_next;
                    end
                end
            endcase
        end
    end

    assign bus.grant        = grant_reg;
    assign bus.grant_valid  = grant_valid_reg;
    assign bus.grant_idx    = grant_idx_reg;
    assign bus.switch_pulse = switch_pulse_reg;
    assign bus.hold_cnt     = hold_cnt_reg;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Testbench for rr_bus_arbiter. Four configurations share one request/lock stimulus:
//   a: RR, MAX_HOLD=4   b: RR, MAX_HOLD=0   c: fixed priority, MAX_HOLD=4
//   d: RR, NUM_REQ=3, MAX_HOLD=5
// Each DUT is compared against an ownership model every cycle.
module tb_rr_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_drv;
    logic       lock_drv;

    always #5 clk = ~clk;

    rr_bus_arbiter_if #(.NUM_REQ(4)) bus_a ();
    rr_bus_arbiter_if #(.NUM_REQ(4)) bus_b ();
    rr_bus_arbiter_if #(.NUM_REQ(4)) bus_c ();
    rr_bus_arbiter_if #(.NUM_REQ(3)) bus_d ();

    assign bus_a.req  = req_drv;
    assign bus_a.lock = lock_drv;
    assign bus_b.req  = req_drv;
    assign bus_b.lock = lock_drv;
    assign bus_c.req  = req_drv;
    assign bus_c.lock = lock_drv;
    assign bus_d.req  = req_drv[2:0];
    assign bus_d.lock = lock_drv;

    rr_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .PRIO_MODE(0)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    rr_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(0), .PRIO_MODE(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
    rr_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .PRIO_MODE(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));
    rr_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(5), .PRIO_MODE(0)) u_d (.clk(clk), .reset(reset), .bus(bus_d));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: who owns the bus, for how long, and whether ownership just changed.
    typedef struct {
        bit valid;
        int idx;
        int hold;
        bit pulse;
    } mst_t;

    mst_t  ms [4];
    int    cfg_n  [4] = '{4, 4, 4, 3};
    int    cfg_mh [4] = '{4, 0, 4, 5};
    int    cfg_pm [4] = '{0, 0, 1, 0};
    string names  [4] = '{"a", "b", "c", "d"};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Walk the candidates in priority order and return the first one that requests, or -1.
    function automatic int pick(input int k, input logic [3:0] r, input bit excl);
        for (int j = 0; j < cfg_n[k]; j++) begin
            int c;
            c = (cfg_pm[k] != 0) ? j : (ms[k].idx + 1 + j) % cfg_n[k];
            if (r[c] && !(excl && c == ms[k].idx)) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input logic [3:0] r, input bit lk);
        int p;
        p = pick(k, r, ms[k].valid);
        ms[k].pulse = 1'b0;
        if (!ms[k].valid) begin
            if (p >= 0) begin
                ms[k].valid = 1'b1; ms[k].idx = p; ms[k].hold = 0; ms[k].pulse = 1'b1;
            end
        end else if (!r[ms[k].idx]) begin
            if (p >= 0) begin
                ms[k].idx = p; ms[k].hold = 0; ms[k].pulse = 1'b1;
            end else begin
                ms[k].valid = 1'b0;
            end
        end else if (cfg_mh[k] != 0 && ms[k].hold >= cfg_mh[k] - 1 && !lk && p >= 0) begin
            ms[k].idx = p; ms[k].hold = 0; ms[k].pulse = 1'b1;
        end else if (ms[k].hold < 255) begin
            ms[k].hold++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            ms[k].valid = 1'b0; ms[k].idx = cfg_n[k] - 1; ms[k].hold = 0; ms[k].pulse = 1'b0;
        end
    endtask

    task automatic check_all(input string ctx);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] g;
            logic       v;
            logic       sp;
            int         gidx;
            int         hc;
            case (k)
                0: begin g = bus_a.grant; v = bus_a.grant_valid; gidx = 32'(bus_a.grant_idx);
                         sp = bus_a.switch_pulse; hc = 32'(bus_a.hold_cnt); end
                1: begin g = bus_b.grant; v = bus_b.grant_valid; gidx = 32'(bus_b.grant_idx);
                         sp = bus_b.switch_pulse; hc = 32'(bus_b.hold_cnt); end
                2: begin g = bus_c.grant; v = bus_c.grant_valid; gidx = 32'(bus_c.grant_idx);
                         sp = bus_c.switch_pulse; hc = 32'(bus_c.hold_cnt); end
                default: begin g = {1'b0, bus_d.grant}; v = bus_d.grant_valid; gidx = 32'(bus_d.grant_idx);
                         sp = bus_d.switch_pulse; hc = 32'(bus_d.hold_cnt); end
            endcase
            check_eq($sformatf("%s/%s grant", ctx, names[k]), 32'(g),
                     ms[k].valid ? (32'd1 << ms[k].idx) : 32'd0);
            check_eq($sformatf("%s/%s valid", ctx, names[k]), 32'(v), 32'(ms[k].valid));
            check_eq($sformatf("%s/%s idx", ctx, names[k]), gidx, ms[k].idx);
            check_eq($sformatf("%s/%s pulse", ctx, names[k]), 32'(sp), 32'(ms[k].pulse));
            if (ms[k].valid) check_eq($sformatf("%s/%s hold", ctx, names[k]), hc, ms[k].hold);
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input logic [3:0] r, input bit lk);
        req_drv  = r;
        lock_drv = lk;
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k, r, lk);
        cyc++;
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        req_drv  = 4'b0000;
        lock_drv = 1'b0;
        reset    = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        check_eq("reset/a hold", 32'(bus_a.hold_cnt), 32'd0);
        reset = 1'b0;
    endtask

    // Assert reset between edges and check that the grant drops without any clock edge.
    task automatic async_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all("areset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    int         t3_idx [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int         t2_exp [5] = '{0, 1, 2, 3, 0};
    int         order [$];
    logic [3:0] r;
    bit         lk;

    initial begin
        reset    = 1'b1;
        req_drv  = 4'b0000;
        lock_drv = 1'b0;

        // First grant after reset goes to the first requester at or after index 0.
        do_reset();
        cycle(4'b1010, 1'b0);
        check_eq("t1 grant", 32'(bus_a.grant), 32'b0010);
        check_eq("t1 idx", 32'(bus_a.grant_idx), 32'd1);
        check_eq("t1 pulse", 32'(bus_a.switch_pulse), 32'd1);
        cycle(4'b1010, 1'b0);
        check_eq("t1 pulse off", 32'(bus_a.switch_pulse), 32'd0);

        // Round-robin fairness with no hold limit: each owner releases after 3 owned cycles.
        do_reset();
        order.delete();
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            r = 4'b1111;
            if (ms[1].valid && ms[1].hold == 2) r[ms[1].idx] = 1'b0;
            cycle(r, 1'b0);
            if (bus_b.switch_pulse) order.push_back(32'(bus_b.grant_idx));
        end
        check_eq("t2 switches", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t2 order[%0d]", i), (i < order.size()) ? order[i] : 99, t2_exp[i]);
        end

        // Forced rotation with MAX_HOLD=4.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(4'b0011, 1'b0);
            check_eq($sformatf("t3 idx[%0d]", i), 32'(bus_a.grant_idx), t3_idx[i]);
            if (i < 8) check_eq($sformatf("t3 hold[%0d]", i), 32'(bus_a.hold_cnt), i % 4);
        end

        // Lock suppresses rotation; dropping lock after expiry rotates at the next edge.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(4'b0011, 1'b1);
        check_eq("t4 idx locked", 32'(bus_a.grant_idx), 32'd0);
        check_eq("t4 hold locked", 32'(bus_a.hold_cnt), 32'd9);
        cycle(4'b0011, 1'b0);
        check_eq("t4 grant unlocked", 32'(bus_a.grant), 32'b0010);
        check_eq("t4 pulse unlocked", 32'(bus_a.switch_pulse), 32'd1);

        // Fixed priority: the lowest index wins on release; going idle keeps grant_idx.
        do_reset();
        cycle(4'b1100, 1'b0);
        check_eq("t5 first idx", 32'(bus_c.grant_idx), 32'd2);
        cycle(4'b1001, 1'b0);
        check_eq("t5 grant", 32'(bus_c.grant), 32'b0001);
        cycle(4'b0000, 1'b0);
        check_eq("t5 idle grant", 32'(bus_c.grant), 32'd0);
        check_eq("t5 idle idx", 32'(bus_c.grant_idx), 32'd0);
        check_eq("t5 idle pulse", 32'(bus_c.switch_pulse), 32'd0);

        // Reset during ownership by master 3.
        do_reset();
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        check_eq("t6 owner", 32'(bus_a.grant_idx), 32'd3);
        async_reset();
        check_eq("t6 grant dropped", 32'(bus_a.grant), 32'd0);
        cycle(4'b1001, 1'b0);
        check_eq("t6 grant after", 32'(bus_a.grant), 32'b0001);

        // Randomized traffic: requests are sticky, lock is sparse, resets are occasional.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            lk = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            cycle(r, lk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
